// File: rtl/tpu_pkg.sv
// Shared TPU defaults and the per-lane delay rule used by the skew buffer and its bench.
package tpu_pkg;

  localparam int unsigned TPU_DATA_W = 32;
  localparam int unsigned TPU_LANES  = 4;

  // Skew staggers lane k later by k; deskew mirrors it so the last lane is shortest.
  function automatic int unsigned lane_delay(input int unsigned k,
                                             input int unsigned lanes,
                                             input int unsigned base_delay,
                                             input int unsigned reverse);
    if (reverse != 0) begin
      return base_delay + lanes - 1 - k;
    end
    return base_delay + k;
  endfunction

endpackage

// File: rtl/skew_lane.sv
// One lane of the skew buffer: a DEPTH-stage {valid, data} shift chain with stall and flush.
// SKEW_ZERO_FILL_EN masks the output data to zero whenever the last stage is invalid.
module skew_lane
  import tpu_pkg::*;
#(
  parameter int unsigned DATA_W = TPU_DATA_W,
  parameter int unsigned DEPTH  = 1
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_en,
  input  logic              i_flush,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_busy
);

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];

  // Invalid entries still shift; only the valid bit qualifies them.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (i_flush) begin
      valid_d = '0;
      for (int j = 0; j < DEPTH; j++) data_d[j] = '0;
    end else if (i_en) begin
      valid_d[0] = i_valid;
      data_d[0]  = i_data;
      for (int j = 1; j < DEPTH; j++) begin
        valid_d[j] = valid_q[j-1];
        data_d[j]  = data_q[j-1];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      valid_q <= '0;
      for (int j = 0; j < DEPTH; j++) data_q[j] <= '0;
    end else begin
      valid_q <= valid_d;
      for (int j = 0; j < DEPTH; j++) data_q[j] <= data_d[j];
    end
  end

  assign o_valid = valid_q[DEPTH-1];
  assign o_busy  = |valid_q;

`ifdef SKEW_ZERO_FILL_EN
  assign o_data = data_q[DEPTH-1] & {DATA_W{valid_q[DEPTH-1]}};
`else
  assign o_data = data_q[DEPTH-1];
`endif

endmodule

// File: rtl/systolic_skew_buffer.sv
// Per-lane delay buffer feeding (skew) or draining (deskew) a systolic array edge.
// Optional SKEW_ZERO_FILL_EN forces invalid output lanes to zero.
module systolic_skew_buffer
  import tpu_pkg::*;
#(
  parameter int unsigned DATA_W     = TPU_DATA_W,
  parameter int unsigned LANES      = TPU_LANES,
  parameter int unsigned BASE_DELAY = 1,
  parameter int unsigned REVERSE    = 0
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic                    i_en,
  input  logic                    i_flush,
  input  logic                    i_valid,
  input  logic [LANES*DATA_W-1:0] i_data,
  output logic [LANES-1:0]        o_valid,
  output logic [LANES*DATA_W-1:0] o_data,
  output logic                    o_busy
);

  logic [LANES-1:0] lane_busy;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    localparam int unsigned LaneDepth = lane_delay(k, LANES, BASE_DELAY, REVERSE);

    skew_lane #(
      .DATA_W (DATA_W),
      .DEPTH  (LaneDepth)
    ) u_lane (
      .i_clk   (i_clk),
      .i_rstn  (i_rstn),
      .i_en    (i_en),
      .i_flush (i_flush),
      .i_valid (i_valid),
      .i_data  (i_data[k*DATA_W +: DATA_W]),
      .o_valid (o_valid[k]),
      .o_data  (o_data[k*DATA_W +: DATA_W]),
      .o_busy  (lane_busy[k])
    );
  end

  assign o_busy = |lane_busy;

endmodule
